// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared types and constants for the display frame sequencer:
//               raster FSM state encoding, one-hot frame-mux select codes
//               and the default raster geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    // Raster sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } state_t;

    // One-hot select codes, bit order {sel_buf1, sel_blank, sel_buf0}
    localparam logic [2:0] SEL_BUF0  = 3'b001;
    localparam logic [2:0] SEL_BLANK = 3'b010;
    localparam logic [2:0] SEL_BUF1  = 3'b100;

    // Default raster geometry (640x480 active)
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_BLANK  = 160;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_BLANK  = 45;

endpackage : display_pkg
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// ============================================================================
// Module      : raster_counter
// Description : Horizontal/vertical raster position counters with wrap.
//               Held at the origin while clear is high, otherwise advances
//               one pixel slot per clock. Flags mark the last active and
//               last overall slot of each dimension.
// Revision    : 1.0 - initial release
// ============================================================================
module raster_counter
    import display_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_BLANK  = DEF_V_BLANK
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic h_act_last,
    output logic h_last,
    output logic v_act_last,
    output logic v_last
);

    localparam int c_h_total = H_ACTIVE + H_BLANK;
    localparam int c_v_total = V_ACTIVE + V_BLANK;
    localparam int c_hw      = $clog2(c_h_total);
    localparam int c_vw      = $clog2(c_v_total);

    logic [c_hw-1:0] r_hcnt;
    logic [c_vw-1:0] r_vcnt;

    assign h_act_last = (r_hcnt == c_hw'(H_ACTIVE - 1));
    assign h_last     = (r_hcnt == c_hw'(c_h_total - 1));
    assign v_act_last = (r_vcnt == c_vw'(V_ACTIVE - 1));
    assign v_last     = (r_vcnt == c_vw'(c_v_total - 1));

    // Advance position; line wrap bumps the line counter, frame wrap clears both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (clear) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (h_last) begin
            r_hcnt <= '0;
            r_vcnt <= v_last ? '0 : r_vcnt + c_vw'(1);
        end else begin
            r_hcnt <= r_hcnt + c_hw'(1);
        end
    end

endmodule : raster_counter
`default_nettype wire

// File: rtl/frame_buffer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_sequencer
// Description : Raster sequencer for a ping-pong frame store. Issues linear
//               read addresses to the front buffer and drives the one-hot
//               frame-mux selects one cycle behind each read. Writer swap
//               requests are honoured only on entry to vertical blank.
//               Option macro: FRAME_REPEAT_EN - a frame with no swap re-shows
//               the current front buffer instead of blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer_sequencer
    import display_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_BLANK  = DEF_V_BLANK,
    parameter int ADDR_W   = $clog2(H_ACTIVE * V_ACTIVE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              back_buf,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              sel_buf0,
    output logic              sel_blank,
    output logic              sel_buf1,
    output logic              frame_start
);

`ifdef FRAME_REPEAT_EN
    localparam logic c_repeat_en = 1'b1;
`else
    localparam logic c_repeat_en = 1'b0;
`endif

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
    logic              r_rd_en, w_rd_en_nxt;
    logic              r_frame_start, w_frame_start_nxt;
    logic              r_swap_ack, w_swap_ack_nxt;
    logic              r_back_buf, w_back_buf_nxt;
    logic              r_frame_valid, w_frame_valid_nxt;
    logic              r_show_frame, w_show_frame_nxt;
    logic [2:0]        r_sel, w_sel_nxt;

    logic w_h_act_last, w_h_last, w_v_act_last, w_v_last;
    logic w_cnt_clear;

    // Counters sit at the origin while idle so the first slot after enable is pixel 0
    assign w_cnt_clear = !enable || (r_state == IDLE);

    raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_ACTIVE (V_ACTIVE),
        .V_BLANK  (V_BLANK)
    ) u_raster_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (w_cnt_clear),
        .h_act_last (w_h_act_last),
        .h_last     (w_h_last),
        .v_act_last (w_v_act_last),
        .v_last     (w_v_last)
    );

    // Next-state, address, swap decision and select pipeline
    always_comb begin
        w_state_nxt       = r_state;
        w_rd_addr_nxt     = r_rd_addr;
        w_frame_start_nxt = 1'b0;
        w_swap_ack_nxt    = 1'b0;
        w_back_buf_nxt    = r_back_buf;
        w_frame_valid_nxt = r_frame_valid;
        w_show_frame_nxt  = r_show_frame;

        if (!enable) begin
            // Enable has priority over everything, including a pending swap
            w_state_nxt      = IDLE;
            w_rd_addr_nxt    = '0;
            w_show_frame_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt       = ACTIVE;
                    w_rd_addr_nxt     = '0;
                    w_frame_start_nxt = 1'b1;
                end
                ACTIVE: begin
                    w_rd_addr_nxt = r_rd_addr + ADDR_W'(1);
                    if (w_h_act_last) begin
                        w_state_nxt = HBLANK;
                    end
                end
                HBLANK: begin
                    if (w_h_last) begin
                        if (w_v_act_last) begin
                            // Vertical blank entry: the only point a swap is taken
                            w_state_nxt       = VBLANK;
                            w_back_buf_nxt    = r_back_buf ^ swap_req;
                            w_frame_valid_nxt = r_frame_valid | swap_req;
                            w_swap_ack_nxt    = swap_req;
                            w_show_frame_nxt  = swap_req | (c_repeat_en & r_frame_valid);
                        end else begin
                            w_state_nxt = ACTIVE;
                        end
                    end
                end
                VBLANK: begin
                    if (w_h_last && w_v_last) begin
                        w_state_nxt       = ACTIVE;
                        w_rd_addr_nxt     = '0;
                        w_frame_start_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end

        w_rd_en_nxt = (w_state_nxt == ACTIVE);

        // Select follows the read strobe by one cycle; front = ~back_buf
        if (!enable) begin
            w_sel_nxt = SEL_BLANK;
        end else if (r_rd_en && r_show_frame) begin
            w_sel_nxt = r_back_buf ? SEL_BUF0 : SEL_BUF1;
        end else begin
            w_sel_nxt = SEL_BLANK;
        end
    end

    // Register state and every output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_rd_addr     <= '0;
            r_rd_en       <= 1'b0;
            r_frame_start <= 1'b0;
            r_swap_ack    <= 1'b0;
            r_back_buf    <= 1'b1;
            r_frame_valid <= 1'b0;
            r_show_frame  <= 1'b0;
            r_sel         <= SEL_BLANK;
        end else begin
            r_state       <= w_state_nxt;
            r_rd_addr     <= w_rd_addr_nxt;
            r_rd_en       <= w_rd_en_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_swap_ack    <= w_swap_ack_nxt;
            r_back_buf    <= w_back_buf_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_show_frame  <= w_show_frame_nxt;
            r_sel         <= w_sel_nxt;
        end
    end

    assign swap_ack    = r_swap_ack;
    assign back_buf    = r_back_buf;
    assign rd_en       = r_rd_en;
    assign rd_addr     = r_rd_addr;
    assign frame_start = r_frame_start;
    assign sel_buf0    = r_sel[0];
    assign sel_blank   = r_sel[1];
    assign sel_buf1    = r_sel[2];

endmodule : frame_buffer_sequencer
`default_nettype wire

// File: tb/tb_frame_buffer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_buffer_sequencer
// Description : Directed self-checking bench for frame_buffer_sequencer on a
//               4x3 active raster (6x4 total, 24-cycle frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_buffer_sequencer;

`ifdef FRAME_REPEAT_EN
    localparam bit c_rep = 1'b1;
`else
    localparam bit c_rep = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       swap_req;
    logic       swap_ack;
    logic       back_buf;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic       sel_buf0;
    logic       sel_blank;
    logic       sel_buf1;
    logic       frame_start;

    int tests = 0;
    int fails = 0;

    frame_buffer_sequencer #(
        .H_ACTIVE (4),
        .H_BLANK  (2),
        .V_ACTIVE (3),
        .V_BLANK  (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .back_buf    (back_buf),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .sel_buf0    (sel_buf0),
        .sel_blank   (sel_blank),
        .sel_buf1    (sel_buf1),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s @%0d observed=%0d expected=%0d", tag, idx, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input int idx);
        chk("rst_sel_blank", idx, sel_blank, 1);
        chk("rst_sel_buf0", idx, sel_buf0, 0);
        chk("rst_sel_buf1", idx, sel_buf1, 0);
        chk("rst_rd_en", idx, rd_en, 0);
        chk("rst_rd_addr", idx, rd_addr, 0);
        chk("rst_swap_ack", idx, swap_ack, 0);
        chk("rst_frame_start", idx, frame_start, 0);
        chk("rst_back_buf", idx, back_buf, 1);
    endtask

    // Slot p of a 6x4 frame is an active pixel on lines 0..2, columns 0..3
    function automatic bit act(input int p);
        return ((p / 6) < 3) && ((p % 6) < 4);
    endfunction

    initial begin
        int f, p;
        bit on;
        bit show_f [4];
        bit buf1_f [4];
        bit exp_back;

        // Frame 0 blank; frame 1 shows buffer 1; frame 2 buffer 0; frame 3 no swap
        show_f = '{1'b0, 1'b1, 1'b1, c_rep};
        buf1_f = '{1'b0, 1'b1, 1'b0, 1'b0};

        rst_n    = 1'b0;
        enable   = 1'b0;
        swap_req = 1'b0;
        repeat (3) step();
        chk_reset(0);

        rst_n = 1'b1;
        step();
        chk("idle_sel_blank", 1, sel_blank, 1);
        chk("idle_rd_en", 1, rd_en, 0);
        chk("idle_frame_start", 1, frame_start, 0);

        enable = 1'b1;
        step();

        // Four full frames: addresses, strobes, frame pulses, swaps and selects
        for (int g = 0; g < 96; g++) begin
            f = g / 24;
            p = g % 24;
            on = (p >= 1) && act(p - 1) && show_f[f];
            exp_back = (g < 18) ? 1'b1 : ((g < 42) ? 1'b0 : 1'b1);
            chk("rd_en", g, rd_en, act(p));
            if (act(p)) chk("rd_addr", g, rd_addr, (p / 6) * 4 + (p % 6));
            chk("frame_start", g, frame_start, (p == 0));
            chk("swap_ack", g, swap_ack, (g == 18 || g == 42));
            chk("back_buf", g, back_buf, exp_back);
            chk("sel_buf0", g, sel_buf0, on && !buf1_f[f]);
            chk("sel_buf1", g, sel_buf1, on && buf1_f[f]);
            chk("sel_blank", g, sel_blank, !on);
            if (g == 10 || g == 29) swap_req = 1'b1;
            if (g == 18 || g == 42) swap_req = 1'b0;
            step();
        end

        // Drop enable mid-line at address 5 (line 1, column 1)
        repeat (7) step();
        chk("mid_rd_addr", 103, rd_addr, 5);
        chk("mid_rd_en", 103, rd_en, 1);
        enable = 1'b0;
        step();
        chk("dis_rd_en", 104, rd_en, 0);
        chk("dis_rd_addr", 104, rd_addr, 0);
        chk("dis_sel_blank", 104, sel_blank, 1);
        chk("dis_sel_buf0", 104, sel_buf0, 0);
        chk("dis_sel_buf1", 104, sel_buf1, 0);
        chk("dis_back_buf", 104, back_buf, 1);
        repeat (2) step();

        // Re-enable restarts the raster at pixel 0 with a frame pulse
        enable = 1'b1;
        step();
        chk("re_frame_start", 107, frame_start, 1);
        chk("re_rd_en", 107, rd_en, 1);
        chk("re_rd_addr", 107, rd_addr, 0);
        chk("re_back_buf", 107, back_buf, 1);

        // Swap request and enable drop on the vertical-blank entry edge
        repeat (17) step();
        chk("pre_vb_rd_en", 124, rd_en, 0);
        swap_req = 1'b1;
        enable   = 1'b0;
        step();
        chk("race_swap_ack", 125, swap_ack, 0);
        chk("race_back_buf", 125, back_buf, 1);
        chk("race_sel_blank", 125, sel_blank, 1);
        swap_req = 1'b0;
        step();
        chk("race_swap_ack2", 126, swap_ack, 0);

        // Asynchronous reset mid-ACTIVE, asserted between clock edges
        enable = 1'b1;
        repeat (3) step();
        chk("pre_rst_rd_en", 129, rd_en, 1);
        chk("pre_rst_rd_addr", 129, rd_addr, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset(130);
        rst_n = 1'b1;
        enable = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_frame_buffer_sequencer
`default_nettype wire
